// File: rtl/approx_pkg.sv
// Shared Q4.12 fixed-point definitions for the log-domain approximators.
package approx_pkg;

    localparam int Q_FRAC_BITS = 12;
    localparam int Q_WIDTH     = 16;

    typedef logic [Q_WIDTH-1:0] q4_12_t;

    localparam q4_12_t Q_ONE = 16'h1000;
    localparam q4_12_t Q_MAX = 16'hFFFF;

endpackage

// File: rtl/pow2_mant_corr.sv
// Combinational fraction -> 13-bit mantissa (1+f), with an optional tent correction
// compiled in by POW2_APPROX_CORR_EN.
module pow2_mant_corr
    import approx_pkg::*;
(
    input  logic [Q_FRAC_BITS-1:0] frac,
    output logic [Q_FRAC_BITS:0]   mant
);

`ifdef POW2_APPROX_CORR_EN
    logic [Q_FRAC_BITS-1:0] dist;
    logic [Q_FRAC_BITS-1:0] corr;

    // Distance to the nearest integer exponent, scaled by 3/16 to bend the linear
    // mantissa towards the true 2^f curve.
    always_comb begin
        dist = frac;
        corr = '0;
        mant = '0;
        if (frac[Q_FRAC_BITS-1]) begin
            dist = (Q_FRAC_BITS)'((Q_FRAC_BITS+1)'(Q_ONE) - {1'b0, frac});
        end
        corr = (dist >> 3) + (dist >> 4);
        mant = (Q_FRAC_BITS+1)'(Q_ONE) + {1'b0, frac} - {1'b0, corr};
    end
`else
    assign mant = (Q_FRAC_BITS+1)'(Q_ONE) + {1'b0, frac};
`endif

endmodule

// File: rtl/pow2_approx.sv
// 3-stage valid/ready pipeline approximating y = 2^x (signed Q4.12 in, unsigned Q4.12 out).
// Optional mantissa correction: define POW2_APPROX_CORR_EN.
module pow2_approx
    import approx_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_WIDTH-1:0] in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] out_y,
    output logic               out_sat
);

    logic                    stall;
    logic                    s1_valid;
    logic                    s2_valid;
    logic signed [3:0]       s1_int;
    logic signed [3:0]       s2_int;
    logic [Q_FRAC_BITS-1:0]  s1_frac;
    logic [Q_FRAC_BITS:0]    s2_mant;
    logic [Q_FRAC_BITS:0]    mant_next;
    logic [3:0]              neg_shift;
    q4_12_t                  y_next;
    logic                    sat_next;

    // A single global stall keeps every stage in lockstep with the output register.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    pow2_mant_corr u_mant (
        .frac (s1_frac),
        .mant (mant_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_y   <= y_next;
                out_sat <= sat_next;
            end
        end
    end

    // Datapath registers carry no reset; their contents only matter under a valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_int  <= $signed(in_x[Q_WIDTH-1:Q_FRAC_BITS]);
            s1_frac <= in_x[Q_FRAC_BITS-1:0];
            s2_int  <= s1_int;
            s2_mant <= mant_next;
        end
    end

    // Exponents 0..3 never overflow 16 bits; 4..7 clip; negatives shift right by -i.
    always_comb begin
        y_next    = '0;
        sat_next  = 1'b0;
        neg_shift = 4'd0 - $unsigned(s2_int);
        if (!s2_int[3] && s2_int[2]) begin
            y_next   = Q_MAX;
            sat_next = 1'b1;
        end else if (!s2_int[3]) begin
            y_next = {3'b000, s2_mant} << s2_int[1:0];
        end else begin
            y_next = {3'b000, s2_mant} >> neg_shift;
        end
    end

endmodule
